// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: round-robin issue of NREQ reservation-station ops onto a
// shared combinational ALU, with a one-entry registered writeback stage.
module alu_issue_arbiter #(
  parameter int NREQ  = 4,
  parameter int TAG_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*32-1:0]    req_a,
  input  logic [NREQ*32-1:0]    req_b,
  input  logic [NREQ*4-1:0]     req_ctrl,
  input  logic [NREQ*TAG_W-1:0] req_tag,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  output logic [3:0]            alu_ctrl,
  input  logic [31:0]           alu_result,
  input  logic                  alu_zero,
  input  logic                  alu_negative,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [TAG_W-1:0]      wb_tag,
  output logic [31:0]           wb_result,
  output logic                  wb_zero,
  output logic                  wb_negative,
  output logic [15:0]           issued_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0][31:0]      w_a, w_b;
  logic [NREQ-1:0][3:0]       w_ctrl;
  logic [NREQ-1:0][TAG_W-1:0] w_tag;

  logic [PW-1:0]    r_rr_ptr;
  logic             r_wb_valid;
  logic [TAG_W-1:0] r_wb_tag;
  logic [31:0]      r_wb_result;
  logic             r_wb_zero;
  logic             r_wb_negative;
  logic [15:0]      r_issued_cnt;

  logic          w_can_accept;
  logic          w_gnt_vld;
  logic [PW-1:0] w_gnt;
  logic          w_fire;
  logic [PW-1:0] w_ptr_nxt;

  // Split the flat per-requester buses into indexable lanes.
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign w_a[i]    = req_a[32*i +: 32];
    assign w_b[i]    = req_b[32*i +: 32];
    assign w_ctrl[i] = req_ctrl[4*i +: 4];
    assign w_tag[i]  = req_tag[TAG_W*i +: TAG_W];
  end

  // Requester index k positions after p, wrapping modulo NREQ.
  function automatic logic [PW-1:0] rot(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  assign w_can_accept = ~r_wb_valid | wb_ready;

  // Round-robin search from r_rr_ptr; walking backwards lets the nearest hit win.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (req_valid[rot(r_rr_ptr, k)]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = rot(r_rr_ptr, k);
      end
    end
  end

  assign w_fire    = w_gnt_vld & w_can_accept & ~rst;
  assign w_ptr_nxt = (w_gnt == PW'(NREQ-1)) ? '0 : w_gnt + PW'(1);

  // One-hot grant and operand mux; ALU inputs idle at zero when nothing issues.
  always_comb begin
    req_ready = '0;
    alu_a     = '0;
    alu_b     = '0;
    alu_ctrl  = 4'b0000;
    if (w_fire) begin
      req_ready[w_gnt] = 1'b1;
      alu_a            = w_a[w_gnt];
      alu_b            = w_b[w_gnt];
      alu_ctrl         = w_ctrl[w_gnt];
    end
  end

  // Writeback entry: load on issue, clear on drain, hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr      <= '0;
      r_wb_valid    <= 1'b0;
      r_wb_tag      <= '0;
      r_wb_result   <= '0;
      r_wb_zero     <= 1'b0;
      r_wb_negative <= 1'b0;
      r_issued_cnt  <= '0;
    end else if (w_fire) begin
      r_rr_ptr      <= w_ptr_nxt;
      r_wb_valid    <= 1'b1;
      r_wb_tag      <= w_tag[w_gnt];
      r_wb_result   <= alu_result;
      r_wb_zero     <= alu_zero;
      r_wb_negative <= alu_negative;
      r_issued_cnt  <= r_issued_cnt + 16'd1;
    end else if (r_wb_valid & wb_ready) begin
      r_wb_valid <= 1'b0;
    end
  end

  assign wb_valid    = r_wb_valid;
  assign wb_tag      = r_wb_tag;
  assign wb_result   = r_wb_result;
  assign wb_zero     = r_wb_zero;
  assign wb_negative = r_wb_negative;
  assign issued_cnt  = r_issued_cnt;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: directed scenarios then random traffic, all
// checked against a transaction-level model of the arbiter and writeback stage.
module tb_alu_issue_arbiter;

  localparam int NREQ  = 4;
  localparam int TAG_W = 6;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid, req_ready;
  logic [NREQ*32-1:0]    req_a, req_b;
  logic [NREQ*4-1:0]     req_ctrl;
  logic [NREQ*TAG_W-1:0] req_tag;
  logic [31:0]           alu_a, alu_b, alu_result;
  logic [3:0]            alu_ctrl;
  logic                  alu_zero, alu_negative;
  logic                  wb_valid, wb_ready, wb_zero, wb_negative;
  logic [TAG_W-1:0]      wb_tag;
  logic [31:0]           wb_result;
  logic [15:0]           issued_cnt;

  // Stimulus held per requester
  logic [31:0]      op_a [NREQ];
  logic [31:0]      op_b [NREQ];
  logic [3:0]       op_c [NREQ];
  logic [TAG_W-1:0] op_t [NREQ];

  // Model state
  int               m_ptr;
  bit               m_wbv;
  logic [TAG_W-1:0] m_tag;
  logic [31:0]      m_res;
  bit               m_zero, m_neg;
  logic [15:0]      m_cnt;

  int total = 0;
  int bad   = 0;
  logic [NREQ-1:0] obs_ready;
  logic [31:0] saved_res;
  logic [TAG_W-1:0] saved_tag;

  alu_issue_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_negative(alu_negative),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag),
    .wb_result(wb_result), .wb_zero(wb_zero), .wb_negative(wb_negative),
    .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: {negative, zero, result}
  function automatic logic [33:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
    logic [31:0] r;
    case (c)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << b[4:0];
      4'd6: r = a >> b[4:0];
      4'd7: r = $unsigned($signed(a) >>> b[4:0]);
      4'd8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: r = (a < b) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return {r[31], (r == 32'd0), r};
  endfunction

  always_comb {alu_negative, alu_zero, alu_result} = alu_ref(alu_a, alu_b, alu_ctrl);

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_a[32*i +: 32]       = op_a[i];
      req_b[32*i +: 32]       = op_b[i];
      req_ctrl[4*i +: 4]      = op_c[i];
      req_tag[TAG_W*i +: TAG_W] = op_t[i];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      case ($urandom_range(0, 3))
        0:       op_a[i] = 32'hFFFF_FFFF;
        1:       op_a[i] = $urandom_range(0, 4);
        default: op_a[i] = $urandom;
      endcase
      op_b[i] = ($urandom_range(0, 3) == 0) ? op_a[i] : $urandom;
      op_c[i] = 4'($urandom_range(0, 15));
      op_t[i] = TAG_W'($urandom);
    end
  endtask

  // One clock: check combinational outputs mid-cycle, then the registered state.
  task automatic cycle();
    int g;
    bit found, fire;
    logic [33:0] r;
    #2;
    found = 0;
    g = 0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1;
        g = idx;
      end
    end
    fire = found && (!m_wbv || wb_ready) && !rst;
    obs_ready = req_ready;
    chk("req_ready", 64'(req_ready), fire ? 64'(1 << g) : 64'd0);
    chk("alu_a", 64'(alu_a), fire ? 64'(op_a[g]) : 64'd0);
    chk("alu_b", 64'(alu_b), fire ? 64'(op_b[g]) : 64'd0);
    chk("alu_ctrl", 64'(alu_ctrl), fire ? 64'(op_c[g]) : 64'd0);
    @(posedge clk);
    #1;
    if (rst) begin
      m_ptr = 0; m_wbv = 0; m_tag = '0; m_res = '0; m_zero = 0; m_neg = 0; m_cnt = '0;
    end else if (fire) begin
      r = alu_ref(op_a[g], op_b[g], op_c[g]);
      m_wbv = 1; m_tag = op_t[g]; m_res = r[31:0]; m_zero = r[32]; m_neg = r[33];
      m_ptr = (g + 1) % NREQ;
      m_cnt = m_cnt + 16'd1;
    end else if (m_wbv && wb_ready) begin
      m_wbv = 0;
    end
    chk("wb_valid", 64'(wb_valid), 64'(m_wbv));
    chk("wb_tag", 64'(wb_tag), 64'(m_tag));
    chk("wb_result", 64'(wb_result), 64'(m_res));
    chk("wb_zero", 64'(wb_zero), 64'(m_zero));
    chk("wb_negative", 64'(wb_negative), 64'(m_neg));
    chk("issued_cnt", 64'(issued_cnt), 64'(m_cnt));
  endtask

  task automatic one_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    req_valid = 4'b0001;
    op_a[0] = a; op_b[0] = b; op_c[0] = c; op_t[0] = 6'd9;
    cycle();
    #0;
  endtask

  initial begin
    m_ptr = 0; m_wbv = 0; m_tag = '0; m_res = '0; m_zero = 0; m_neg = 0; m_cnt = '0;
    rst = 1'b1; req_valid = '0; wb_ready = 1'b1;
    rand_ops();
    @(posedge clk); #1;
    cycle();
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_cnt", 64'(issued_cnt), 64'd0);
    chk("rst_result", 64'(wb_result), 64'd0);

    // Single op: 5 - 3 from requester 0
    rst = 1'b0;
    req_valid = 4'b0001;
    op_a[0] = 32'd5; op_b[0] = 32'd3; op_c[0] = 4'b0001; op_t[0] = 6'd7;
    cycle();
    chk("single_ready", 64'(obs_ready), 64'b0001);
    chk("single_valid", 64'(wb_valid), 64'd1);
    chk("single_result", 64'(wb_result), 64'd2);
    chk("single_tag", 64'(wb_tag), 64'd7);
    chk("single_flags", 64'({wb_zero, wb_negative}), 64'd0);
    chk("single_cnt", 64'(issued_cnt), 64'd1);

    // Round robin with all requesters pending; pointer now at 1
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      rand_ops();
      cycle();
      chk("rr_grant", 64'(obs_ready), 64'(1 << ((1 + i) % NREQ)));
      chk("rr_valid", 64'(wb_valid), 64'd1);
      chk("rr_cnt", 64'(issued_cnt), 64'(2 + i));
    end

    // Backpressure: entry must hold bit-stable, no grants
    wb_ready = 1'b0;
    saved_res = wb_result;
    saved_tag = wb_tag;
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      cycle();
      chk("bp_ready", 64'(obs_ready), 64'd0);
      chk("bp_result", 64'(wb_result), 64'(saved_res));
      chk("bp_tag", 64'(wb_tag), 64'(saved_tag));
      chk("bp_cnt", 64'(issued_cnt), 64'd6);
    end
    wb_ready = 1'b1;
    cycle();
    chk("bp_release_ready", 64'(obs_ready), 64'b0100);
    chk("bp_release_valid", 64'(wb_valid), 64'd1);
    chk("bp_release_cnt", 64'(issued_cnt), 64'd7);

    // Fairness skip: pointer at 3, requesters 1 and 3 pending
    req_valid = 4'b1010;
    cycle();
    chk("skip_g3", 64'(obs_ready), 64'b1000);
    cycle();
    chk("skip_g1", 64'(obs_ready), 64'b0010);
    req_valid = 4'b1111;
    cycle();
    chk("skip_ptr2", 64'(obs_ready), 64'b0100);

    // Signed/unsigned compare, illegal op, negative result
    req_valid = 4'b0000;
    cycle();
    cycle();
    one_op(32'hFFFF_FFFF, 32'd1, 4'b1000);
    chk("slt_res", 64'(wb_result), 64'd1);
    one_op(32'hFFFF_FFFF, 32'd1, 4'b1001);
    chk("sltu_res", 64'(wb_result), 64'd0);
    chk("sltu_zero", 64'(wb_zero), 64'd1);
    one_op(32'hFFFF_FFFF, 32'd1, 4'b1111);
    chk("illegal_res", 64'(wb_result), 64'd0);
    chk("illegal_flags", 64'({wb_zero, wb_negative}), 64'b10);
    one_op(32'd0, 32'd1, 4'b0001);
    chk("sub_neg_res", 64'(wb_result), 64'hFFFF_FFFF);
    chk("sub_neg_flag", 64'(wb_negative), 64'd1);

    // Reset while a stalled entry is held and everyone is requesting
    wb_ready = 1'b0;
    one_op(32'd1, 32'd2, 4'b0000);
    req_valid = 4'b1111;
    rst = 1'b1;
    cycle();
    chk("rstmid_ready", 64'(obs_ready), 64'd0);
    chk("rstmid_valid", 64'(wb_valid), 64'd0);
    chk("rstmid_cnt", 64'(issued_cnt), 64'd0);
    rst = 1'b0;
    wb_ready = 1'b1;
    cycle();
    chk("rstmid_first", 64'(obs_ready), 64'b0001);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rand_ops();
      req_valid = 4'($urandom);
      wb_ready  = ($urandom_range(0, 9) < 7);
      rst       = ($urandom_range(0, 63) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
